rx_uart: RTL and testbench
==========================

Name: rx_uart

Overview:
- UART 8N1 receiver, LSB first; receive-side counterpart of the transmit baud-rate/serializer path.
- Converts the asynchronous serial line `rx` into parallel bytes on `d`, with a one-cycle valid strobe.
- Generates its own bit timing from `ck` and samples at mid-bit.
- Sits between the board RX pin and the consumer logic (display/registers).

Parameters:
- CLKS_PER_BIT, 434, ck cycles per bit (50 MHz / 115200). Must be ≥ 4 and even.
- DATA_BITS, 8, data bits per frame.

Ports:
- ck    input   1  system clock; all logic on posedge.
- rst   input   1  synchronous, active-high reset.
- en    input   1  receiver enable; 0 forces idle.
- rx    input   1  asynchronous serial line; idles high.
- d     output  8  last correctly received byte.
- dv    output  1  one-cycle strobe: `d` updated with a new byte.
- fe    output  1  one-cycle strobe: framing error (stop bit read 0).
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Clocking/reset: single clock `ck`. Reset is synchronous and active-high on `rst`.
- Reset values: state=IDLE, bit counter=0, index=0, shift=0, `d`=0, `dv`=0, `fe`=0, `busy`=0, synchronizer flops=1.
- Synchronizer: `rx` passes through a 2-flop synchronizer to produce `rxs`. This adds 2 cycles of latency; all decisions use `rxs` only.
- Counter: `cnt` is $clog2(CLKS_PER_BIT) bits wide and is cleared on every state change.
- IDLE:
  - `en`=1 and `rxs`=0 → START.
  - Otherwise stay in IDLE.
- START:
  - When `cnt` = CLKS_PER_BIT/2−1, sample `rxs`.
  - `rxs`=0 → DATA with index=0.
  - `rxs`=1 → IDLE (glitch rejected; no strobe).
- DATA:
  - When `cnt` = CLKS_PER_BIT−1, load `rxs` into `shift[index]` and increment index.
  - After the sample at index=DATA_BITS−1 → STOP.
- STOP:
  - When `cnt` = CLKS_PER_BIT−1, sample `rxs`.
  - `rxs`=1 → `d` ← `shift`, `dv`=1 for exactly one cycle, → IDLE.
  - `rxs`=0 → `fe`=1 for exactly one cycle, `d` unchanged, → BRK.
- BRK: remain until `rxs`=1, then → IDLE. A held-low line (break) therefore produces exactly one `fe` and never retriggers.
- Strobes: `dv` and `fe` are registered and never high simultaneously.
  - `dv` rises on the cycle after the stop-bit sample edge.
  - Latency from the `rx` falling edge to `dv` = 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT cycles, ±1.
- Back-to-back frames: returning to IDLE at mid-stop allows a start bit immediately after the stop bit with zero idle time.
- `en`=0 in any state: next cycle state=IDLE, `cnt`=0, index=0. No `dv`/`fe` is generated for the aborted frame; `d` keeps its value.
- `rst` mid-frame: same abort, plus `d`=0.
- `busy` is combinational from the state register: high in START/DATA/STOP/BRK.

Decomposition:
- Package `uart_pkg`:
  - State enum {IDLE, START, DATA, STOP, BRK}.
  - DATA_BITS default.
  - Shared default CLKS_PER_BIT = 434 (the transmit side uses the same constant).
- Sub-module `sync_2ff`:
  - Ports: `ck`, `rst`, `a`, `y`; reset value 1.
  - Reused for any other asynchronous input.

Test Plan (CLKS_PER_BIT=8 for sim speed; 1 bit = 8 ck):
- Frame 0x55 (start, bits 1,0,1,0,1,0,1,0, stop=1) → `dv` high for one cycle at 78±1 cycles after the falling edge; `d`=0x55; `fe`=0; `busy` falls with `dv`.
- 2-cycle low glitch on an idle line → `busy` high for ~4 cycles then 0; no `dv`, no `fe`; `d` unchanged.
- Frame 0xA3 with stop bit=0, then line held low for 40 cycles → one `fe` pulse, no `dv`, `d` stays 0x55. After the line returns high, frame 0x3C → `dv`, `d`=0x3C.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `dv` pulses 80 cycles apart; `d`=0x00 then 0xFF.
- `en` dropped during bit 4 of frame 0x81 → `busy`=0 next cycle; no `dv`/`fe`. Re-enable, send 0x81 → `d`=0x81.
- `rst` pulsed for 1 cycle mid-DATA → next cycle `d`=0x00, `busy`=0, `dv`=0. A following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous level input, resets high
module sync_2ff (
    input  logic ck,
    input  logic rst,
    input  logic a,
    output logic y
);

    logic q1;

    always_ff @(posedge ck) begin
        if (rst) begin
            q1 <= 1'b1;
            y  <= 1'b1;
        end else begin
            q1 <= a;
            y  <= q1;
        end
    end

endmodule

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - 8N1 UART receiver with mid-bit sampling, framing error and break handling
module rx_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d,
    output logic                 dv,
    output logic                 fe,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rxs;
    logic                 dv_n, fe_n, bit_tick;

    sync_2ff u_sync_rx (
        .ck (ck),
        .rst(rst),
        .a  (rx),
        .y  (rxs)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        dv_n     = 1'b0;
        fe_n     = 1'b0;
        bit_tick = 1'b0;
        case (state)
            IDLE:  if (en && !rxs) state_n = START;
            START: if (cnt == CNT_MID) state_n = rxs ? IDLE : DATA;
            DATA: begin
                if (cnt == CNT_END) begin
                    bit_tick = 1'b1;
                    if (idx == IDX_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_END) begin
                    if (rxs) begin
                        state_n = IDLE;
                        dv_n    = 1'b1;
                    end else begin
                        state_n = BRK;
                        fe_n    = 1'b1;
                    end
                end
            end
            BRK:     if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Disable wins over everything: the frame in flight is dropped silently.
        if (!en) begin
            state_n  = IDLE;
            dv_n     = 1'b0;
            fe_n     = 1'b0;
            bit_tick = 1'b0;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            d     <= '0;
            dv    <= 1'b0;
            fe    <= 1'b0;
        end else begin
            state <= state_n;
            dv    <= dv_n;
            fe    <= fe_n;
            if (state_n != state || state == IDLE || cnt == CNT_END)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state_n != state || !en)
                idx <= '0;
            else if (bit_tick)
                idx <= idx + 1'b1;
            if (bit_tick)
                shift[idx] <= rxs;
            if (dv_n)
                d <= shift;
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - directed scoreboard bench for rx_uart at 8 clocks per bit
module tb_rx_uart;

    localparam int CPB = 8;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] d;
    logic       dv, fe, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_count = 0;
    int fe_count = 0;
    int last_dv = 0;
    int dv_gap = 0;
    int t_fall = 0;
    int dv0, fe0, busy_hi;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    rx_uart #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .ck  (ck),
        .rst (rst),
        .en  (en),
        .rx  (rx),
        .d   (d),
        .dv  (dv),
        .fe  (fe),
        .busy(busy)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge ck) begin
        if (dv | fe) chk("dv_fe_exclusive", {31'd0, dv & fe}, 32'd0);
        if (dv) begin
            dv_count++;
            dv_gap  = cyc - last_dv;
            last_dv = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_dv", 32'd1, 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                chk("d_at_dv", {24'd0, d}, {24'd0, exp_b});
                chk("busy_at_dv", {31'd0, busy}, 32'd0);
            end
        end
        if (fe) fe_count++;
    end

    task automatic drive_bit(input logic v);
        @(posedge ck);
        #1 rx = v;
        repeat (CPB - 1) @(posedge ck);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge ck);
        #1 rx = 1'b0;
        t_fall = cyc;
        repeat (CPB - 1) @(posedge ck);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ck);
        @(negedge ck);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("rst_d", {24'd0, d}, 32'd0);
        chk("rst_dv", {31'd0, dv}, 32'd0);
        chk("rst_fe", {31'd0, fe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Frame 0x55 and its latency
        exp_q.push_back(8'h55);
        dv0 = dv_count;
        send_frame(8'h55, 1'b1);
        idle(2);
        chk("f55_dv_count", dv_count - dv0, 1);
        chk("f55_latency_ok", {31'd0, (last_dv - t_fall >= 77) && (last_dv - t_fall <= 79)}, 32'd1);
        chk("f55_fe", fe_count, 0);

        // Two-cycle glitch
        dv0 = dv_count; fe0 = fe_count; busy_hi = 0;
        @(posedge ck); #1 rx = 1'b0;
        @(posedge ck); #1 rx = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge ck);
            if (busy) busy_hi++;
        end
        chk("glitch_busy_len_ok", {31'd0, busy_hi >= 3 && busy_hi <= 5}, 32'd1);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);
        chk("glitch_no_dv", dv_count - dv0, 0);
        chk("glitch_no_fe", fe_count - fe0, 0);
        chk("glitch_d", {24'd0, d}, 32'h55);

        // Framing error then break
        dv0 = dv_count; fe0 = fe_count;
        send_frame(8'hA3, 1'b0);
        repeat (40) @(posedge ck);
        #1 rx = 1'b1;
        idle(6);
        chk("brk_fe_once", fe_count - fe0, 1);
        chk("brk_no_dv", dv_count - dv0, 0);
        chk("brk_d_kept", {24'd0, d}, 32'h55);
        chk("brk_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(2);
        chk("f3c_dv_count", dv_count - dv0, 1);

        // Back-to-back frames, no idle gap
        dv0 = dv_count;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2);
        chk("b2b_dv_count", dv_count - dv0, 2);
        chk("b2b_gap", dv_gap, 10 * CPB);
        chk("b2b_d", {24'd0, d}, 32'hFF);

        // Enable dropped during bit 4 of 0x81
        dv0 = dv_count; fe0 = fe_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i == 0);
        @(posedge ck); #1 rx = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("en_busy_before", {31'd0, busy}, 32'd1);
        @(posedge ck); #1 en = 1'b0;
        @(posedge ck);
        @(negedge ck);
        chk("en_busy_after", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge ck);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(posedge ck); #1 en = 1'b1;
        idle(20);
        chk("en_no_dv", dv_count - dv0, 0);
        chk("en_no_fe", fe_count - fe0, 0);
        chk("en_d_kept", {24'd0, d}, 32'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(2);
        chk("f81_dv_count", dv_count - dv0, 1);

        // Reset pulse mid-DATA
        dv0 = dv_count;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(i[0]);
        @(posedge ck); #1 rst = 1'b1; rx = 1'b1;
        @(posedge ck);
        @(negedge ck);
        chk("rstmid_d", {24'd0, d}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_dv", {31'd0, dv}, 32'd0);
        rst = 1'b0;
        idle(20);
        chk("rstmid_no_dv", dv_count - dv0, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(4);
        chk("f7e_dv_count", dv_count - dv0, 1);
        chk("f7e_d", {24'd0, d}, 32'h7E);

        chk("queue_empty", exp_q.size(), 0);
        chk("total_fe", fe_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
